croc_clk_div: RTL and testbench
===============================

CROC_CLK_DIV -- requirements
Module: croc_clk_div

Interface
REQ-001 SHALL have parameter NumChannels, default 2, number of independent divider channels.
REQ-002 SHALL have parameter CntWidth, default 16, width of divisor and counter.
REQ-003 SHALL have parameter DefaultDiv, default 610, divisor loaded into every channel at reset.
REQ-004 SHALL have port clk_i  input  1  single clock; all logic on its rising edge.
REQ-005 SHALL have port rst_i  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port en_i  input  NumChannels  per-channel run request.
REQ-007 SHALL have port div_i  input  NumChannels x CntWidth  per-channel new divisor.
REQ-008 SHALL have port div_we_i  input  NumChannels  one-cycle write strobe for div_i.
REQ-009 SHALL have port clk_o  output  NumChannels  divided clock, driven directly by a flop.
REQ-010 SHALL have port tick_o  output  NumChannels  one-cycle pulse per divided period.
REQ-011 SHALL have port div_pending_o  output  NumChannels  shadow divisor written, not yet applied.
REQ-012 SHALL have port running_o  output  NumChannels  channel in RUN or STOP state.

Function
REQ-013 Each channel SHALL implement FSM IDLE, RUN, STOP; channels fully independent.
REQ-014 Active divisor D SHALL be max(written value, 2); values 0 and 1 clamp to 2.
REQ-015 IDLE: cnt_q = 0, clk_o = 0, tick_o = 0; en_i sampled high moves to RUN.
REQ-016 First RUN cycle SHALL have cnt_q = 0, clk_o = 1, tick_o = 1 (one cycle after en_i sampled high).
REQ-017 RUN: cnt_q SHALL increment by 1 per cycle and wrap from D-1 to 0.
REQ-018 clk_o SHALL be 1 iff cnt_q < ceil(D/2), i.e. high ceil(D/2) cycles, low floor(D/2) cycles.
REQ-019 tick_o SHALL be 1 iff cnt_q = 0 in RUN or STOP.
REQ-020 en_i sampled low in RUN SHALL move to STOP; STOP completes the period, moving to IDLE on the wrap cycle (cnt_q = D-1). No runt pulse is permitted.
REQ-021 en_i sampled high in STOP SHALL return to RUN with no counter disturbance.
REQ-022 div_we_i SHALL capture div_i into a shadow register and set div_pending_o the next cycle.
REQ-023 A pending shadow SHALL become D at the next wrap (cnt_q = D-1 -> 0) or the next cycle if IDLE; div_pending_o SHALL clear in that same cycle.
REQ-024 A write in the wrap cycle itself SHALL be applied at that wrap.
REQ-025 A write while pending SHALL overwrite the shadow; the last value wins.
REQ-026 The counter SHALL never exceed D-1; no CntWidth overflow.

Reset
REQ-027 rst_i high SHALL asynchronously force:
- FSM to IDLE
- cnt_q, clk_o, tick_o, div_pending_o, running_o to 0
- D and shadow to DefaultDiv
REQ-028 Reset deasserted SHALL take effect on the next clk_i edge; reset asserted mid-period SHALL drop clk_o to 0 immediately.

Structure
REQ-029 Package croc_clk_div_pkg SHALL hold the FSM state enum and the minimum-divisor constant (2).
REQ-030 A per-channel sub-module croc_clk_div_chan SHALL be instantiated NumChannels times in a generate loop.

Verification
REQ-031 D=610 (reset value), en_i=1 -> clk_o 305 high / 305 low; tick_o every 610 cycles; first tick one cycle after enable.
REQ-032 D=5 -> clk_o pattern 1,1,1,0,0 repeating; tick_o on each leading 1.
REQ-033 Write D=4 at cnt_q=2 of D=10 -> div_pending_o=1 until wrap; next period 2 high / 2 low; pending cleared.
REQ-034 en_i drops at cnt_q=1 of D=8 -> running_o stays 1 until cnt_q=7; then IDLE with clk_o=0; no short pulse.
REQ-035 Write div_i=0 -> D=2; clk_o toggles every cycle; tick_o every 2 cycles.
REQ-036 rst_i pulse mid-high phase -> clk_o=0 without clock edge; after release channel 1 unaffected by channel 0 writes.

Source files
------------

// File: rtl/croc_clk_div_pkg.sv
// Shared types and constants for the croc_clk_div programmable clock divider.
//   chan_state_e : per-channel divider FSM state
//   MinDiv       : smallest divisor a channel will ever run with
package croc_clk_div_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_STOP = 2'd2
  } chan_state_e;

  localparam int unsigned MinDiv = 2;

endpackage

// File: rtl/croc_clk_div_chan.sv
// One divider channel: counts 0..D-1, drives a duty-balanced divided clock
// (high ceil(D/2) cycles, low floor(D/2) cycles) and a tick at each period
// start. Divisor updates go through a shadow register and only take effect
// on a period boundary (or while idle) so the output never glitches.
//
// Ports
//   clk_i         : clock, all logic on rising edge
//   rst_i         : asynchronous active-high reset
//   en_i          : run request
//   div_i         : new divisor value
//   div_we_i      : one-cycle write strobe for div_i
//   clk_o         : divided clock (flop output)
//   tick_o        : one-cycle pulse on the first cycle of each period
//   div_pending_o : shadow divisor written but not yet active
//   running_o     : channel in RUN or STOP
module croc_clk_div_chan
  import croc_clk_div_pkg::*;
#(
  parameter int unsigned CntWidth   = 16,
  parameter int unsigned DefaultDiv = 610
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                en_i,
  input  logic [CntWidth-1:0] div_i,
  input  logic                div_we_i,
  output logic                clk_o,
  output logic                tick_o,
  output logic                div_pending_o,
  output logic                running_o
);

  chan_state_e         state_q, state_d;
  logic [CntWidth-1:0] cnt_q, cnt_d;
  logic [CntWidth-1:0] div_q, div_d;
  logic [CntWidth-1:0] shadow_q, shadow_d;
  logic [CntWidth-1:0] half_d;
  logic                pending_q, pending_d;
  logic                clk_q, clk_d;
  logic                tick_q, tick_d;
  logic                run_q, run_d;
  logic                wrap;

  // Divisors below MinDiv cannot produce a high and a low phase.
  function automatic logic [CntWidth-1:0] clamp_div(input logic [CntWidth-1:0] v);
    return (v < CntWidth'(MinDiv)) ? CntWidth'(MinDiv) : v;
  endfunction

  // Last cycle of the current period.
  assign wrap = (state_q != ST_IDLE) && (cnt_q == (div_q - CntWidth'(1)));

  // Next-state, counter, divisor and output decode.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    div_d     = div_q;
    shadow_d  = shadow_q;
    pending_d = pending_q;
    half_d    = '0;
    run_d     = 1'b0;
    clk_d     = 1'b0;
    tick_d    = 1'b0;

    // A disable seen on the wrap cycle finishes the period straight into IDLE.
    unique case (state_q)
      ST_IDLE: begin
        if (en_i) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (wrap)       state_d = en_i ? ST_RUN : ST_IDLE;
        else if (!en_i) state_d = ST_STOP;
      end
      ST_STOP: begin
        if (wrap)      state_d = en_i ? ST_RUN : ST_IDLE;
        else if (en_i) state_d = ST_RUN;
      end
      default: state_d = ST_IDLE;
    endcase

    if ((state_q == ST_IDLE) || wrap) cnt_d = '0;
    else                               cnt_d = cnt_q + CntWidth'(1);

    // Pending shadow lands on a period boundary or immediately when idle.
    if (pending_q && (wrap || (state_q == ST_IDLE))) begin
      div_d     = clamp_div(shadow_q);
      pending_d = 1'b0;
    end

    // A write on the wrap cycle bypasses the shadow and applies at this wrap.
    if (div_we_i) begin
      shadow_d = div_i;
      if (wrap) begin
        div_d     = clamp_div(div_i);
        pending_d = 1'b0;
      end else begin
        pending_d = 1'b1;
      end
    end

    // ceil(D/2) without widening: floor(D/2) + lsb.
    half_d = (div_d >> 1) + {{(CntWidth-1){1'b0}}, div_d[0]};
    run_d  = (state_d != ST_IDLE);
    clk_d  = run_d && (cnt_d < half_d);
    tick_d = run_d && (cnt_d == '0);
  end

  // State and output registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      div_q     <= CntWidth'(DefaultDiv);
      shadow_q  <= CntWidth'(DefaultDiv);
      pending_q <= 1'b0;
      clk_q     <= 1'b0;
      tick_q    <= 1'b0;
      run_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      div_q     <= div_d;
      shadow_q  <= shadow_d;
      pending_q <= pending_d;
      clk_q     <= clk_d;
      tick_q    <= tick_d;
      run_q     <= run_d;
    end
  end

  assign clk_o         = clk_q;
  assign tick_o        = tick_q;
  assign div_pending_o = pending_q;
  assign running_o     = run_q;

endmodule

// File: rtl/croc_clk_div.sv
// Multi-channel programmable clock divider: NumChannels independent
// croc_clk_div_chan instances sharing one clock and reset.
//
// Ports
//   clk_i         : clock
//   rst_i         : asynchronous active-high reset
//   en_i          : per-channel run request
//   div_i         : per-channel new divisor
//   div_we_i      : per-channel divisor write strobe
//   clk_o         : per-channel divided clock
//   tick_o        : per-channel period-start pulse
//   div_pending_o : per-channel shadow divisor pending
//   running_o     : per-channel RUN/STOP indication
module croc_clk_div
  import croc_clk_div_pkg::*;
#(
  parameter int unsigned NumChannels = 2,
  parameter int unsigned CntWidth    = 16,
  parameter int unsigned DefaultDiv  = 610
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic [NumChannels-1:0]              en_i,
  input  logic [NumChannels-1:0][CntWidth-1:0] div_i,
  input  logic [NumChannels-1:0]              div_we_i,
  output logic [NumChannels-1:0]              clk_o,
  output logic [NumChannels-1:0]              tick_o,
  output logic [NumChannels-1:0]              div_pending_o,
  output logic [NumChannels-1:0]              running_o
);

  // One fully independent divider per channel.
  for (genvar g = 0; g < NumChannels; g++) begin : g_chan
    croc_clk_div_chan #(
      .CntWidth   (CntWidth),
      .DefaultDiv (DefaultDiv)
    ) u_chan (
      .clk_i         (clk_i),
      .rst_i         (rst_i),
      .en_i          (en_i[g]),
      .div_i         (div_i[g]),
      .div_we_i      (div_we_i[g]),
      .clk_o         (clk_o[g]),
      .tick_o        (tick_o[g]),
      .div_pending_o (div_pending_o[g]),
      .running_o     (running_o[g])
    );
  end

endmodule

// File: tb/tb_croc_clk_div.sv
module tb_croc_clk_div;

  localparam int unsigned N   = 2;
  localparam int unsigned W   = 16;
  localparam int unsigned DEF = 610;

  logic                clk_i;
  logic                rst_i;
  logic [N-1:0]        en_i;
  logic [N-1:0][W-1:0] div_i;
  logic [N-1:0]        div_we_i;
  logic [N-1:0]        clk_o;
  logic [N-1:0]        tick_o;
  logic [N-1:0]        div_pending_o;
  logic [N-1:0]        running_o;

  int errors = 0;
  int checks = 0;

  // Behavioural model: a channel is either active or not, sits at a position
  // within its period, and has an active / shadow divisor.
  int m_act  [N];
  int m_pos  [N];
  int m_d    [N];
  int m_sh   [N];
  int m_pend [N];

  croc_clk_div #(
    .NumChannels (N),
    .CntWidth    (W),
    .DefaultDiv  (DEF)
  ) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .en_i          (en_i),
    .div_i         (div_i),
    .div_we_i      (div_we_i),
    .clk_o         (clk_o),
    .tick_o        (tick_o),
    .div_pending_o (div_pending_o),
    .running_o     (running_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  function automatic int clampi(input int v);
    return (v < 2) ? 2 : v;
  endfunction

  function automatic void model_reset();
    for (int c = 0; c < N; c++) begin
      m_act[c] = 0; m_pos[c] = 0; m_d[c] = DEF; m_sh[c] = DEF; m_pend[c] = 0;
    end
  endfunction

  function automatic void model_step();
    for (int c = 0; c < N; c++) begin
      bit last;
      last = (m_act[c] != 0) && (m_pos[c] == m_d[c] - 1);
      if ((m_pend[c] != 0) && (last || m_act[c] == 0)) begin
        m_d[c] = clampi(m_sh[c]);
        m_pend[c] = 0;
      end
      if (div_we_i[c]) begin
        m_sh[c] = int'(div_i[c]);
        if (last) begin
          m_d[c] = clampi(int'(div_i[c]));
          m_pend[c] = 0;
        end else begin
          m_pend[c] = 1;
        end
      end
      if (m_act[c] == 0) begin
        if (en_i[c]) begin m_act[c] = 1; m_pos[c] = 0; end
      end else if (last) begin
        m_pos[c] = 0;
        m_act[c] = en_i[c] ? 1 : 0;
      end else begin
        m_pos[c] = m_pos[c] + 1;
      end
    end
  endfunction

  function automatic logic [4*N-1:0] exp_vec();
    logic [N-1:0] e_clk, e_tick, e_pend, e_run;
    for (int c = 0; c < N; c++) begin
      e_run[c]  = (m_act[c] != 0);
      e_clk[c]  = (m_act[c] != 0) && (m_pos[c] < (m_d[c] + 1) / 2);
      e_tick[c] = (m_act[c] != 0) && (m_pos[c] == 0);
      e_pend[c] = (m_pend[c] != 0);
    end
    return {e_clk, e_tick, e_pend, e_run};
  endfunction

  task automatic tick();
    @(posedge clk_i);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    en_i = '0; div_we_i = '0; div_i = '0;
    rst_i = 1'b1;
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    model_reset();
  endtask

  task automatic write_idle(input int c, input int v);
    div_we_i[c] = 1'b1; div_i[c] = W'(v);
    tick();
    div_we_i[c] = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    en_i = '0; div_we_i = '0; div_i = '0; rst_i = 1'b0;
    #2 rst_i = 1'b1;
    #1;
    if (clk_o !== '0) begin errors++; $display("FAIL reset_clk got %b expected 0", clk_o); end
    checks++;
    if (tick_o !== '0) begin errors++; $display("FAIL reset_tick got %b expected 0", tick_o); end
    checks++;
    if (div_pending_o !== '0) begin errors++; $display("FAIL reset_pend got %b expected 0", div_pending_o); end
    checks++;
    if (running_o !== '0) begin errors++; $display("FAIL reset_run got %b expected 0", running_o); end
    checks++;
    en_i = '1;
    @(posedge clk_i); #1;
    if ({clk_o, running_o} !== '0) begin
      errors++; $display("FAIL reset_hold got %b expected 0", {clk_o, running_o});
    end
    checks++;
    en_i = '0;
    rst_i = 1'b0;
    model_reset();
    tick();
    if ({clk_o, tick_o, div_pending_o, running_o} !== exp_vec()) begin
      errors++; $display("FAIL reset_idle got %b expected %b", {clk_o, tick_o, div_pending_o, running_o}, exp_vec());
    end
    checks++;
  endtask

  task automatic test_default_div();
    int hi = 0, t0 = -1, t1 = -1;
    do_reset();
    en_i[0] = 1'b1;
    for (int i = 0; i < 1220; i++) begin
      tick();
      if ({clk_o, tick_o, div_pending_o, running_o} !== exp_vec()) begin
        errors++; $display("FAIL default_div cycle %0d got %b expected %b", i, {clk_o, tick_o, div_pending_o, running_o}, exp_vec());
      end
      checks++;
      if (i < 610 && clk_o[0]) hi++;
      if (tick_o[0]) begin
        if (t0 < 0) t0 = i; else if (t1 < 0) t1 = i;
      end
    end
    if (hi != 305) begin errors++; $display("FAIL default_high got %0d expected 305", hi); end
    checks++;
    if (t0 != 0) begin errors++; $display("FAIL default_first_tick got %0d expected 0", t0); end
    checks++;
    if (t1 != 610) begin errors++; $display("FAIL default_second_tick got %0d expected 610", t1); end
    checks++;
  endtask

  task automatic test_div5();
    logic [4:0] pat;
    pat = 5'b00111;
    do_reset();
    write_idle(0, 5);
    en_i[0] = 1'b1;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (clk_o[0] !== pat[i % 5]) begin
        errors++; $display("FAIL div5_clk cycle %0d got %b expected %b", i, clk_o[0], pat[i % 5]);
      end
      checks++;
      if (tick_o[0] !== ((i % 5) == 0)) begin
        errors++; $display("FAIL div5_tick cycle %0d got %b expected %b", i, tick_o[0], (i % 5) == 0);
      end
      checks++;
    end
  endtask

  task automatic test_div_change();
    logic [3:0] pat;
    int guard;
    pat = 4'b0011;
    do_reset();
    write_idle(0, 10);
    en_i[0] = 1'b1;
    guard = 0;
    tick();
    while (m_pos[0] != 2 && guard < 50) begin tick(); guard++; end
    if (guard >= 50) begin errors++; $display("FAIL change_reach_cnt2 got timeout expected cnt 2"); end
    checks++;
    div_we_i[0] = 1'b1; div_i[0] = W'(4);
    tick();
    div_we_i[0] = 1'b0;
    guard = 0;
    while (m_pos[0] != 0 && guard < 50) begin
      if (div_pending_o[0] !== 1'b1) begin
        errors++; $display("FAIL change_pending cnt %0d got %b expected 1", m_pos[0], div_pending_o[0]);
      end
      checks++;
      tick(); guard++;
    end
    if (guard != 7) begin errors++; $display("FAIL change_pending_len got %0d expected 7", guard); end
    checks++;
    for (int k = 0; k < 4; k++) begin
      if ({clk_o[0], div_pending_o[0]} !== {pat[k], 1'b0}) begin
        errors++; $display("FAIL change_newperiod k %0d got %b expected %b", k, {clk_o[0], div_pending_o[0]}, {pat[k], 1'b0});
      end
      checks++;
      tick();
    end
    if (tick_o[0] !== 1'b1) begin errors++; $display("FAIL change_tick4 got %b expected 1", tick_o[0]); end
    checks++;
  endtask

  task automatic test_stop();
    int guard, run_cnt, hi_cnt;
    do_reset();
    write_idle(0, 8);
    en_i[0] = 1'b1;
    tick();
    guard = 0;
    while (m_pos[0] != 1 && guard < 50) begin tick(); guard++; end
    en_i[0] = 1'b0;
    run_cnt = 0; hi_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if ({clk_o, tick_o, div_pending_o, running_o} !== exp_vec()) begin
        errors++; $display("FAIL stop cycle %0d got %b expected %b", i, {clk_o, tick_o, div_pending_o, running_o}, exp_vec());
      end
      checks++;
      if (running_o[0]) run_cnt++;
      if (clk_o[0]) hi_cnt++;
    end
    if (run_cnt != 6) begin errors++; $display("FAIL stop_run_len got %0d expected 6", run_cnt); end
    checks++;
    if (hi_cnt != 2) begin errors++; $display("FAIL stop_high_len got %0d expected 2", hi_cnt); end
    checks++;
    if ({clk_o[0], running_o[0]} !== 2'b00) begin
      errors++; $display("FAIL stop_idle got %b expected 00", {clk_o[0], running_o[0]});
    end
    checks++;
  endtask

  task automatic test_div_zero();
    do_reset();
    write_idle(0, 0);
    en_i[0] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if ({clk_o[0], tick_o[0]} !== {((i % 2) == 0), ((i % 2) == 0)}) begin
        errors++; $display("FAIL div0 cycle %0d got %b expected %b", i, {clk_o[0], tick_o[0]}, {((i % 2) == 0), ((i % 2) == 0)});
      end
      checks++;
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    en_i[0] = 1'b1;
    repeat (10) tick();
    if (clk_o[0] !== 1'b1) begin errors++; $display("FAIL midrst_pre got %b expected 1", clk_o[0]); end
    checks++;
    #2 rst_i = 1'b1;
    #1;
    if ({clk_o[0], running_o[0]} !== 2'b00) begin
      errors++; $display("FAIL midrst_async got %b expected 00", {clk_o[0], running_o[0]});
    end
    checks++;
    #1 rst_i = 1'b0;
    model_reset();
    en_i = '1;
    div_we_i[0] = 1'b1; div_i[0] = W'(3);
    tick();
    div_we_i[0] = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if ({clk_o, tick_o, div_pending_o, running_o} !== exp_vec()) begin
        errors++; $display("FAIL midrst_indep cycle %0d got %b expected %b", i, {clk_o, tick_o, div_pending_o, running_o}, exp_vec());
      end
      checks++;
      if (div_pending_o[1] !== 1'b0) begin
        errors++; $display("FAIL midrst_ch1_pend cycle %0d got %b expected 0", i, div_pending_o[1]);
      end
      checks++;
      tick();
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < N; c++) write_idle(c, int'($urandom_range(0, 9)));
    for (int i = 0; i < 3000; i++) begin
      for (int c = 0; c < N; c++) begin
        en_i[c]     = ($urandom_range(0, 99) < 85);
        div_we_i[c] = ($urandom_range(0, 99) < 5);
        div_i[c]    = W'($urandom_range(0, 12));
      end
      tick();
      if ({clk_o, tick_o, div_pending_o, running_o} !== exp_vec()) begin
        errors++; $display("FAIL random cycle %0d got %b expected %b", i, {clk_o, tick_o, div_pending_o, running_o}, exp_vec());
      end
      checks++;
    end
    en_i = '0; div_we_i = '0;
  endtask

  initial begin
    test_reset();
    test_default_div();
    test_div5();
    test_div_change();
    test_stop();
    test_div_zero();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
